// File: rtl/cdb_broadcaster.sv
// Transmit end of the common data bus: per-source result FIFOs feeding a
// round-robin arbiter that drives one registered broadcast per cycle.
module cdb_broadcaster #(
  parameter int N_SRC  = 4,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC*TAG_W-1:0]    src_tag,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  output logic [N_SRC-1:0]          src_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]  not_empty;
  logic [N_SRC-1:0]  pop;
  logic [TAG_W-1:0]  head_tag  [N_SRC];
  logic [DATA_W-1:0] head_data [N_SRC];

  logic              grant_valid;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W-1:0]  cand;
  logic [SEL_W-1:0]  rr_ptr_reg;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              push;
    logic [TAG_W-1:0]  in_tag;
    logic [DATA_W-1:0] in_data;

    assign in_tag  = src_tag[gi*TAG_W +: TAG_W];
    assign in_data = src_data[gi*DATA_W +: DATA_W];

    // Ready looks only at the registered count, so there is no valid-to-ready path.
    assign src_ready[gi] = rst_n && (count_reg < CNT_W'(DEPTH)) && !flush;

    // Tag 0 means "no producer": the handshake completes but nothing is stored.
    assign push = src_valid[gi] && src_ready[gi] && (in_tag != '0);

    assign not_empty[gi] = (count_reg != '0);
    assign pop[gi]       = grant_valid && (grant_idx == SEL_W'(gi));
    assign head_tag[gi]  = tag_mem[rd_ptr_reg];
    assign head_data[gi] = data_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
      if (push) begin
        tag_mem[wr_ptr_reg]  <= in_tag;
        data_mem[wr_ptr_reg] <= in_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        case ({push, pop[gi]})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // First non-empty source at or after rr_ptr, wrapping around.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = SEL_W'((int'(rr_ptr_reg) + k) % N_SRC);
      if (!grant_valid && not_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
    end else if (flush) begin
      rr_ptr_reg <= '0;
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
    end else if (grant_valid) begin
      rr_ptr_reg <= (grant_idx == SEL_W'(N_SRC - 1)) ? '0 : grant_idx + SEL_W'(1);
      cdb_valid  <= 1'b1;
      cdb_tag    <= head_tag[grant_idx];
      cdb_data   <= head_data[grant_idx];
    end else begin
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
    end
  end

endmodule
